// File: rtl/msg_pkg.sv
// State encodings, character codes and message ROM contents for msg_scroller.
package msg_pkg;

    localparam int unsigned ST_WELCOME = 0;
    localparam int unsigned ST_GAME    = 1;
    localparam int unsigned ST_SCORE   = 2;
    localparam int unsigned ST_ERROR   = 3;
    localparam int unsigned ST_COIN    = 4;

    localparam int unsigned CH_A = 10, CH_B = 11, CH_C = 12, CH_D = 13, CH_E = 14, CH_F = 15;
    localparam int unsigned CH_G = 16, CH_H = 17, CH_I = 18, CH_J = 19, CH_K = 20, CH_L = 21;
    localparam int unsigned CH_M = 22, CH_N = 23, CH_O = 24, CH_P = 25, CH_Q = 26, CH_R = 27;
    localparam int unsigned CH_S = 28, CH_T = 29, CH_U = 30, CH_V = 31, CH_W = 32, CH_X = 33;
    localparam int unsigned CH_Y = 34, CH_Z = 35;
    localparam int unsigned CH_BLANK = 36;

    localparam int unsigned ROM_DEPTH = 8;
    typedef int unsigned rom_text_t [ROM_DEPTH];

    localparam rom_text_t TXT_NONE    = '{default: CH_BLANK};
    localparam rom_text_t TXT_WELCOME = '{CH_H, CH_E, CH_L, CH_L, CH_O,
                                          CH_BLANK, CH_BLANK, CH_BLANK};
    localparam rom_text_t TXT_ERROR   = '{CH_N, CH_O, CH_BLANK, CH_C, CH_O, CH_I, CH_N,
                                          CH_BLANK};
    localparam rom_text_t TXT_COIN    = '{CH_C, CH_O, CH_I, CH_N,
                                          CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK};

    localparam int unsigned LEN_WELCOME = 5;
    localparam int unsigned LEN_ERROR   = 7;
    localparam int unsigned LEN_COIN    = 4;

endpackage

// File: rtl/msg_rom.sv
// Combinational message lookup: (state, index) -> (character, message length).
module msg_rom #(
    parameter int unsigned CHAR_W  = 6,
    parameter int unsigned STATE_W = 4,
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned LEN_W   = 4
) (
    input  logic [STATE_W-1:0] state,
    input  logic [IDX_W-1:0]   idx,
    output logic [CHAR_W-1:0]  chr,
    output logic [LEN_W-1:0]   len
);
    import msg_pkg::*;

    rom_text_t txt;

    // Text and length depend on state only, kept apart from the index path.
    always_comb begin
        txt = TXT_NONE;
        len = '0;
        case (32'(state))
            ST_WELCOME: begin
                txt = TXT_WELCOME;
                len = LEN_W'(LEN_WELCOME);
            end
            ST_ERROR: begin
                txt = TXT_ERROR;
                len = LEN_W'(LEN_ERROR);
            end
            ST_COIN: begin
                txt = TXT_COIN;
                len = LEN_W'(LEN_COIN);
            end
            default: begin
                txt = TXT_NONE;
                len = '0;
            end
        endcase
    end

    always_comb begin
        chr = CHAR_W'(CH_BLANK);
        for (int i = 0; i < ROM_DEPTH; i++) begin
            if (idx == IDX_W'(i)) begin
                chr = CHAR_W'(txt[i]);
            end
        end
    end

endmodule

// File: rtl/msg_scroller.sv
// Scrolling message generator for the character display; define MSG_BLINK_EN to blink
// the ERROR text on alternate scroll steps.
module msg_scroller #(
    parameter int unsigned CHAR_W     = 6,
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned MSG_LEN    = 8,
    parameter int unsigned SCROLL_DIV = 2,
    parameter int unsigned STATE_W    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [STATE_W-1:0]           cur_state,
    input  logic                         ref_sign,
    input  logic [$clog2(DIGITS)-1:0]    refresh,
    output logic [CHAR_W-1:0]            message,
    output logic [$clog2(MSG_LEN+1)-1:0] scroll_pos,
    output logic                         wrap
);
    import msg_pkg::*;

    localparam int unsigned REF_W = $clog2(DIGITS);
    localparam int unsigned POS_W = $clog2(MSG_LEN + 1);
    localparam int unsigned SUM_W = $clog2(MSG_LEN + DIGITS + 1);
    localparam int unsigned DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [SUM_W-1:0]  DIGITS_S = SUM_W'(DIGITS);
    localparam logic [REF_W-1:0]  REF_LAST = REF_W'(DIGITS - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCROLL_DIV - 1);
    localparam logic [CHAR_W-1:0] BLANK_C  = CHAR_W'(CH_BLANK);

    logic [CHAR_W-1:0]  stage1_q, char_d, rom_chr;
    logic [STATE_W-1:0] last_q;
    logic [POS_W-1:0]   pos_q, pos_d, pos_eff, len;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               wrap_d;
    logic [SUM_W-1:0]   ref_s, len_s, sum, idx;
    logic               changed, frame_end, scrolls, blink;

    assign changed   = (cur_state != last_q);
    assign frame_end = ref_sign && (refresh == REF_LAST);
    assign ref_s     = SUM_W'(refresh);
    assign len_s     = SUM_W'(len);
    assign scrolls   = (len_s > DIGITS_S);
    // A restart looks up the new state from position 0.
    assign pos_eff   = changed ? '0 : pos_q;
    assign sum       = SUM_W'(pos_eff) + ref_s;
    // sum < 2(L+1), so one conditional subtract gives the circular index.
    assign idx       = (sum > len_s) ? (sum - (len_s + SUM_W'(1))) : sum;

    msg_rom #(
        .CHAR_W  (CHAR_W),
        .STATE_W (STATE_W),
        .IDX_W   (SUM_W),
        .LEN_W   (POS_W)
    ) u_rom (
        .state (cur_state),
        .idx   (idx),
        .chr   (rom_chr),
        .len   (len)
    );

`ifdef MSG_BLINK_EN
    logic blink_q;
    logic is_error;

    assign is_error = (cur_state == STATE_W'(ST_ERROR));
    assign blink    = blink_q && is_error;

    always_ff @(posedge clk) begin
        if (!rst_n || changed) begin
            blink_q <= 1'b0;
        end else if (is_error && frame_end && (div_q == DIV_LAST) && scrolls) begin
            blink_q <= ~blink_q;
        end
    end
`else
    assign blink = 1'b0;
`endif

    always_comb begin
        char_d = rom_chr;
        if ((ref_s >= DIGITS_S) || (!scrolls && (ref_s >= len_s)) || blink) begin
            char_d = BLANK_C;
        end
    end

    always_comb begin
        pos_d  = pos_q;
        div_d  = div_q;
        wrap_d = 1'b0;
        if (changed) begin
            pos_d = '0;
            div_d = '0;
        end else if (frame_end) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (scrolls) begin
                    if (pos_q == len) begin
                        pos_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage1_q <= '0;
            message  <= '0;
            pos_q    <= '0;
            div_q    <= '0;
            wrap     <= 1'b0;
            last_q   <= '0;
        end else begin
            last_q  <= cur_state;
            pos_q   <= pos_d;
            div_q   <= div_d;
            wrap    <= wrap_d;
            message <= stage1_q;
            if (ref_sign) begin
                stage1_q <= char_d;
            end
        end
    end

    assign scroll_pos = pos_q;

endmodule

// File: tb/tb_msg_scroller.sv
// Self-checking bench for msg_scroller: vector table plus scoreboarded scrolling sequences.
module tb_msg_scroller;

    localparam int DIGITS = 4;
    localparam int NVEC   = 17;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] cur_state;
    logic       ref_sign;
    logic [1:0] refresh;
    logic [5:0] message;
    logic [3:0] scroll_pos;
    logic       wrap;

    always #5 clk = ~clk;

    msg_scroller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cur_state  (cur_state),
        .ref_sign   (ref_sign),
        .refresh    (refresh),
        .message    (message),
        .scroll_pos (scroll_pos),
        .wrap       (wrap)
    );

    typedef struct { int val; int due; } exp_t;
    typedef struct { int st; int r; int exp; } vec_t;

    exp_t exp_q[$];
    vec_t vecs[NVEC];

    int checks = 0, errors = 0, cyc = 0, wrap_cycles = 0;
    int m_state = 0, m_pos = 0, m_div = 0, last_exp = 0;
    bit m_blink = 1'b0;

    int txt_welcome[5] = '{17, 14, 21, 21, 24};
    int txt_error[7]   = '{23, 24, 36, 12, 24, 18, 23};
    int txt_coin[4]    = '{12, 24, 18, 23};

    function automatic int mlen(int st);
        case (st)
            0: return 5;
            3: return 7;
            4: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int mtext(int st, int k);
        case (st)
            0: return txt_welcome[k];
            3: return txt_error[k];
            4: return txt_coin[k];
            default: return 36;
        endcase
    endfunction

    function automatic int mchar(int st, int pos, int d);
        int l, k;
        l = mlen(st);
        if (l <= DIGITS) return (d < l) ? mtext(st, d) : 36;
        k = (pos + d) % (l + 1);
        return (k == l) ? 36 : mtext(st, k);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (wrap === 1'b1) wrap_cycles++;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check("message", {26'd0, message}, e.val);
        end
    endtask

    // One display strobe; expected char comes from the table or from the model.
    task automatic strobe(input int st, input int r, input int tbl_exp, input bit from_tbl);
        exp_t x;
        int   e;
        bit   chg;
        chg = (st != m_state);
        if (chg) begin
            m_state = st;
            m_pos   = 0;
            m_div   = 0;
            m_blink = 1'b0;
        end
        e = mchar(st, m_pos, r);
`ifdef MSG_BLINK_EN
        if (m_blink && st == 3) e = 36;
`endif
        if (from_tbl) e = tbl_exp;
        cur_state = 4'(st);
        refresh   = 2'(r);
        ref_sign  = 1'b1;
        x.val = e;
        x.due = cyc + 2;
        exp_q.push_back(x);
        last_exp = e;
        if (!chg && r == DIGITS - 1) begin
            m_div++;
            if (m_div == 2) begin
                m_div = 0;
                if (mlen(st) > DIGITS) begin
                    m_pos = (m_pos == mlen(st)) ? 0 : m_pos + 1;
                    if (st == 3) m_blink = !m_blink;
                end
            end
        end
        tick();
        ref_sign = 1'b0;
    endtask

    task automatic run_frame(input int st);
        for (int d = 0; d < DIGITS; d++) strobe(st, d, 0, 1'b0);
        check("scroll_pos", {28'd0, scroll_pos}, m_pos);
    endtask

    task automatic drain();
        repeat (3) tick();
        check("scoreboard drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cur_state = '0;
        ref_sign  = 1'b0;
        refresh   = '0;
        vecs = '{'{3, 0, 23}, '{3, 1, 24}, '{3, 2, 36}, '{3, 3, 12},
                 '{1, 0, 36}, '{1, 1, 36}, '{1, 2, 36}, '{1, 3, 36},
                 '{4, 0, 12}, '{4, 1, 24}, '{4, 2, 18}, '{4, 3, 23},
                 '{0, 0, 17}, '{0, 1, 14}, '{0, 2, 21}, '{0, 3, 21},
                 '{7, 0, 36}};

        tick();
        tick();
        check("reset message", {26'd0, message}, 0);
        check("reset scroll_pos", {28'd0, scroll_pos}, 0);
        check("reset wrap", {31'd0, wrap}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) strobe(vecs[i].st, vecs[i].r, vecs[i].exp, 1'b1);
        drain();

        // ERROR text scrolls a full circle over 16 frames.
        wrap_cycles = 0;
        for (int f = 0; f < 16; f++) run_frame(3);
        drain();
        check("wrap pulses after 16 frames", wrap_cycles, 1);
        check("scroll_pos after wrap", {28'd0, scroll_pos}, 0);

        // Short message never scrolls; GAME is blank.
        wrap_cycles = 0;
        for (int f = 0; f < 10; f++) run_frame(4);
        drain();
        check("coin wrap pulses", wrap_cycles, 0);
        run_frame(1);
        drain();

        // State switch coinciding with a strobe restarts at position 0.
        for (int f = 0; f < 6; f++) run_frame(3);
        check("pos before switch", {28'd0, scroll_pos}, 3);
        strobe(0, 0, 0, 1'b0);
        check("pos after switch", {28'd0, scroll_pos}, 0);
        drain();
        check("switch message", {26'd0, message}, 17);

        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold message", {26'd0, message}, last_exp);
        end

        // Reset in the middle of scrolling.
        for (int f = 0; f < 6; f++) run_frame(3);
        strobe(3, 0, 0, 1'b0);
        strobe(3, 1, 0, 1'b0);
        drain();
        rst_n = 1'b0;
        tick();
        check("mid reset message", {26'd0, message}, 0);
        check("mid reset scroll_pos", {28'd0, scroll_pos}, 0);
        check("mid reset wrap", {31'd0, wrap}, 0);
        rst_n   = 1'b1;
        m_state = 0;
        m_pos   = 0;
        m_div   = 0;
        m_blink = 1'b0;
        tick();
        check("post reset stage1", {26'd0, message}, 0);
        run_frame(3);
        run_frame(3);
        run_frame(3);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
